// File: rtl/instr_encoder.sv
// instr_encoder: packs operation requests (op, rd, rs1, rs2, imm) into RV32I instruction
// words (ADD/SUB/OR/AND, ADDI/ORI/ANDI, LW, SW), buffers them in a small FIFO and streams
// them to the instruction-memory loader together with a byte address.
//
// Ports:
//   clk, reset      clock (rising edge), asynchronous active-high reset
//   flush           synchronous clear of FIFO and address counter (err_count kept)
//   in_valid/ready  request handshake; in_ready = !full
//   in_op           0 ADD,1 SUB,2 OR,3 AND,4 ADDI,5 ORI,6 ANDI,7 LW,8 SW, 9-15 illegal
//   in_rd/rs1/rs2   register fields
//   in_imm          12-bit immediate (I-type, LW, SW)
//   out_valid/ready output handshake for the word at the FIFO head
//   out_instr       encoded word at the head (0 while empty)
//   out_addr        byte address labelling the head word
//   err_illegal     one-cycle pulse after an illegal op was consumed
//   err_count       saturating count of consumed illegal ops
module instr_encoder #(
  parameter int unsigned       DEPTH     = 4,
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int unsigned       CNT_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [11:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err_illegal,
  output logic [CNT_W-1:0]  err_count
);

  localparam int unsigned    PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  // Request op codes
  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_OR   = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_ADDI = 4'd4;
  localparam logic [3:0] OP_ORI  = 4'd5;
  localparam logic [3:0] OP_ANDI = 4'd6;
  localparam logic [3:0] OP_LW   = 4'd7;
  localparam logic [3:0] OP_SW   = 4'd8;

  // RV32I major opcodes
  localparam logic [6:0] OPC_R     = 7'b0110011;
  localparam logic [6:0] OPC_I     = 7'b0010011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_WORD = 3'b010;
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  // ---------------------------------------------------------------------------
  // Encoder
  // ---------------------------------------------------------------------------
  logic [31:0] enc_word;
  logic        enc_legal;

  always_comb begin
    enc_word  = '0;
    enc_legal = 1'b1;
    case (in_op)
      OP_ADD:  enc_word = {F7_BASE, in_rs2, in_rs1, F3_ADD, in_rd, OPC_R};
      OP_SUB:  enc_word = {F7_SUB,  in_rs2, in_rs1, F3_ADD, in_rd, OPC_R};
      OP_OR:   enc_word = {F7_BASE, in_rs2, in_rs1, F3_OR,  in_rd, OPC_R};
      OP_AND:  enc_word = {F7_BASE, in_rs2, in_rs1, F3_AND, in_rd, OPC_R};
      OP_ADDI: enc_word = {in_imm, in_rs1, F3_ADD, in_rd, OPC_I};
      OP_ORI:  enc_word = {in_imm, in_rs1, F3_OR,  in_rd, OPC_I};
      OP_ANDI: enc_word = {in_imm, in_rs1, F3_AND, in_rd, OPC_I};
      OP_LW:   enc_word = {in_imm, in_rs1, F3_WORD, in_rd, OPC_LOAD};
      OP_SW:   enc_word = {in_imm[11:5], in_rs2, in_rs1, F3_WORD, in_imm[4:0], OPC_STORE};
      default: enc_legal = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FIFO state
  // ---------------------------------------------------------------------------
  logic [31:0]       mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;

  logic full, empty, accept, push, pop, illegal_acc;

  // Readiness comes only from registered occupancy, so a full FIFO refuses a push even
  // when a pop happens in the same cycle.
  assign full        = (count_q == FULL_CNT);
  assign empty       = (count_q == '0);
  assign accept      = in_valid & ~full;
  assign push        = accept & enc_legal & ~flush;
  assign pop         = ~empty & out_ready & ~flush;
  // Illegal ops still consume the handshake; they are counted even during a flush.
  assign illegal_acc = accept & ~enc_legal;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    addr_d    = addr_q;
    err_d     = illegal_acc;
    err_cnt_d = err_cnt_q;

    if (illegal_acc && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      addr_d   = BASE_ADDR;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
        addr_d   = addr_q + ADDR_W'(4);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + (PTR_W + 1)'(1);
        2'b01:   count_d = count_q - (PTR_W + 1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      addr_q    <= BASE_ADDR;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      addr_q    <= addr_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Storage needs no reset: out_instr is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= enc_word;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign in_ready    = ~full;
  assign out_valid   = ~empty;
  assign out_instr   = empty ? 32'h0 : mem[rd_ptr_q];
  assign out_addr    = addr_q;
  assign err_illegal = err_q;
  assign err_count   = err_cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: table of known encodings, hand-written corner
// sequences (fill/stall, illegal ops, saturation, flush, reset) and a randomized run,
// all compared against a queue-based reference model.
module tb_instr_encoder;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 32;
  localparam int CNT_W  = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_op;
  logic [4:0]        in_rd, in_rs1, in_rs2;
  logic [11:0]       in_imm;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_addr;
  logic              err_illegal;
  logic [CNT_W-1:0]  err_count;

  instr_encoder #(
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W),
    .BASE_ADDR(32'h0),
    .CNT_W    (CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_rd      (in_rd),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_imm     (in_imm),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .out_addr   (out_addr),
    .err_illegal(err_illegal),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit [31:0] mq[$];
  bit [31:0] maddr;
  int        mcnt;
  bit        merr;

  typedef struct {
    int unsigned op, rd, rs1, rs2, imm;
    bit [31:0]   exp;
  } vec_t;

  task automatic check(input string name, input bit [31:0] act, input bit [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Encoding from the field layout, built with plain arithmetic.
  function automatic bit [31:0] ref_enc(int unsigned op, int unsigned rd, int unsigned rs1,
                                        int unsigned rs2, int unsigned imm);
    int unsigned f3;
    if (op <= 3) begin
      f3 = (op == 2) ? 6 : (op == 3) ? 7 : 0;
      return ((op == 1) ? 32 : 0) * (1 << 25) + rs2 * (1 << 20) + rs1 * (1 << 15)
             + f3 * (1 << 12) + rd * (1 << 7) + 'h33;
    end else if (op <= 6) begin
      f3 = (op == 5) ? 6 : (op == 6) ? 7 : 0;
      return imm * (1 << 20) + rs1 * (1 << 15) + f3 * (1 << 12) + rd * (1 << 7) + 'h13;
    end else if (op == 7) begin
      return imm * (1 << 20) + rs1 * (1 << 15) + 2 * (1 << 12) + rd * (1 << 7) + 'h03;
    end
    return (imm / 32) * (1 << 25) + rs2 * (1 << 20) + rs1 * (1 << 15) + 2 * (1 << 12)
           + (imm % 32) * (1 << 7) + 'h23;
  endfunction

  task automatic model_reset();
    mq.delete();
    maddr = 0;
    mcnt  = 0;
    merr  = 0;
  endtask

  // One clock cycle: drive, compare at the falling edge, advance the model at the edge.
  task automatic step(input bit v, input int unsigned op, input int unsigned rd,
                      input int unsigned rs1, input int unsigned rs2, input int unsigned imm,
                      input bit rdy, input bit fl);
    bit acc, pop;
    in_valid  = v;
    in_op     = op[3:0];
    in_rd     = rd[4:0];
    in_rs1    = rs1[4:0];
    in_rs2    = rs2[4:0];
    in_imm    = imm[11:0];
    out_ready = rdy;
    flush     = fl;
    @(negedge clk);
    check("in_ready", {31'b0, in_ready}, {31'b0, mq.size() < DEPTH});
    check("out_valid", {31'b0, out_valid}, {31'b0, mq.size() > 0});
    if (mq.size() > 0) check("out_instr", out_instr, mq[0]);
    check("out_addr", out_addr, maddr);
    check("err_illegal", {31'b0, err_illegal}, {31'b0, merr});
    check("err_count", {24'b0, err_count}, mcnt);
    acc = v && (mq.size() < DEPTH);
    pop = rdy && (mq.size() > 0);
    @(posedge clk);
    #1;
    merr = acc && (op > 8);
    if (merr && mcnt < 255) mcnt++;
    if (fl) begin
      mq.delete();
      maddr = 0;
    end else begin
      if (pop) begin
        void'(mq.pop_front());
        maddr += 4;
      end
      if (acc && op <= 8) mq.push_back(ref_enc(op, rd, rs1, rs2, imm));
    end
  endtask

  task automatic idle(input bit rdy);
    step(1'b0, 0, 0, 0, 0, 0, rdy, 1'b0);
  endtask

  vec_t tbl[9];

  initial begin
    tbl[0] = '{0, 1, 2, 3, 0,     32'h003100B3};
    tbl[1] = '{1, 5, 6, 7, 0,     32'h407302B3};
    tbl[2] = '{4, 1, 0, 0, 'hFFF, 32'hFFF00093};
    tbl[3] = '{8, 0, 3, 2, 8,     32'h0021A423};
    tbl[4] = '{7, 4, 5, 0, 4,     32'h0042A203};
    tbl[5] = '{2, 1, 2, 3, 0,     32'h003160B3};
    tbl[6] = '{3, 1, 2, 3, 0,     32'h003170B3};
    tbl[7] = '{5, 1, 0, 0, 'hFFF, 32'hFFF06093};
    tbl[8] = '{6, 1, 0, 0, 'hFFF, 32'hFFF07093};

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
    model_reset();
    #12;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_out_instr", out_instr, 32'h0);
    check("rst_out_addr", out_addr, 32'h0);
    check("rst_err_illegal", {31'b0, err_illegal}, 32'd0);
    check("rst_err_count", {24'b0, err_count}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    // Known encodings: each word visible one cycle after acceptance, addresses 0,4,8,...
    for (int i = 0; i < 9; i++) begin
      step(1'b1, tbl[i].op, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].imm, 1'b1, 1'b0);
      check("tbl_instr", out_instr, tbl[i].exp);
      check("tbl_addr", out_addr, 32'(i * 4));
    end
    idle(1'b1);

    // Flush to restart addresses, then fill with out_ready low; 5th push stalls.
    step(1'b0, 0, 0, 0, 0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 0, i + 1, 2, 3, 0, 1'b0, 1'b0);
    check("fill_in_ready", {31'b0, in_ready}, 32'd0);
    step(1'b1, 0, 5, 2, 3, 0, 1'b1, 1'b0);  // pop while full: push still refused
    step(1'b1, 0, 5, 2, 3, 0, 1'b0, 1'b0);  // now accepted
    for (int i = 0; i < 6; i++) idle(1'b1);
    check("fill_last_addr", out_addr, 32'h14);

    // Illegal op: nothing queued, one-cycle pulse, count 1
    step(1'b1, 12, 1, 1, 1, 0, 1'b1, 1'b0);
    check("ill_pulse", {31'b0, err_illegal}, 32'd1);
    check("ill_count", {24'b0, err_count}, 32'd1);
    check("ill_empty", {31'b0, out_valid}, 32'd0);
    idle(1'b1);
    for (int i = 0; i < 256; i++) step(1'b1, 9 + (i % 7), 0, 0, 0, 0, 1'b1, 1'b0);
    idle(1'b1);
    check("ill_saturate", {24'b0, err_count}, 32'hFF);

    // Three queued, then flush together with push and pop
    for (int i = 0; i < 3; i++) step(1'b1, 4, i, 1, 0, i, 1'b0, 1'b0);
    step(1'b1, 0, 9, 9, 9, 0, 1'b1, 1'b1);
    check("flush_empty", {31'b0, out_valid}, 32'd0);
    step(1'b1, 7, 3, 4, 0, 16, 1'b0, 1'b0);
    check("flush_addr", out_addr, 32'h0);
    idle(1'b1);

    // Asynchronous reset mid-stream
    for (int i = 0; i < 3; i++) step(1'b1, 1, i, 2, 3, 0, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("mid_rst_valid", {31'b0, out_valid}, 32'd0);
    check("mid_rst_addr", out_addr, 32'h0);
    check("mid_rst_count", {24'b0, err_count}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    @(posedge clk); #1;

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0, ($urandom_range(0, 9) == 0) ? $urandom_range(9, 15)
           : $urandom_range(0, 8), $urandom_range(0, 31), $urandom_range(0, 31),
           $urandom_range(0, 31), $urandom_range(0, 4095), $urandom_range(0, 2) != 0,
           $urandom_range(0, 60) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
